// File: rtl/vector_pkg.sv
// Shared vector/lane geometry and split-sequencer types, common to the split and join paths so the
// lane-to-element mapping is defined in one place.
package vector_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned V      = 20;
  localparam int unsigned LANES  = 4;
  localparam int unsigned STRIDE = V / LANES;

  localparam int unsigned BeatW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned IdxW  = (V > 1) ? $clog2(V) : 1;
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [N-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } split_state_t;

  // Element carried by a lane on a given beat; lanes are STRIDE elements apart.
  function automatic logic [IdxW-1:0] elem_idx(input logic [BeatW-1:0] beat,
                                               input int unsigned lane);
    return IdxW'(beat) + IdxW'(lane * STRIDE);
  endfunction

endpackage

// File: rtl/vector_split_sequencer.sv
// Snapshots a V-element vector and streams it out as STRIDE interleaved beats of LANES elements.
// Optional stall counter output enabled by defining SPLIT_STALL_CNT_EN.
module vector_split_sequencer
  import vector_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start_i,
  input  logic [V-1:0][N-1:0]         vector_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [LANES-1:0][N-1:0]     lanes_o,
  output logic [BeatW-1:0]            beat_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef SPLIT_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt_o
`endif
);

  if (V % LANES != 0) begin : g_bad_cfg
    $error("vector_split_sequencer: V must be a multiple of LANES");
  end

  localparam logic [BeatW-1:0] LastBeat = BeatW'(STRIDE - 1);

  split_state_t         state_q, state_d;
  logic [V-1:0][N-1:0]  vec_q, vec_d;
  logic [BeatW-1:0]     beat_q, beat_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          vec_d   = vector_i;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      vec_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      beat_q  <= beat_d;
    end
  end

  assign valid_o = (state_q == SEND);
  assign beat_o  = beat_q;
  assign last_o  = valid_o && (beat_q == LastBeat);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

  // Lanes read zero whenever no beat is being offered.
  always_comb begin
    lanes_o = '0;
    if (state_q == SEND) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        lanes_o[LaneW'(j)] = vec_q[elem_idx(beat_q, j)];
      end
    end
  end

`ifdef SPLIT_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && start_i) begin
      stall_cnt_d = '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vector_split_sequencer.sv
// Self-checking bench for vector_split_sequencer: directed and random splits against a
// transaction-level model, with a lane-join reassembly of every streamed vector.
module tb_vector_split_sequencer;
  import vector_pkg::*;

  localparam int CW = V * N;
  typedef logic [V-1:0][N-1:0] vec_t;
  typedef logic [CW-1:0]       cw_t;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    start_i;
  vec_t                    vector_i;
  logic                    ready_i;
  logic                    valid_o;
  logic [LANES-1:0][N-1:0] lanes_o;
  logic [BeatW-1:0]        beat_o;
  logic                    last_o;
  logic                    busy_o;
  logic                    done_o;
`ifdef SPLIT_STALL_CNT_EN
  logic [15:0]             stall_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  vector_split_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_i    (start_i),
    .vector_i   (vector_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .lanes_o    (lanes_o),
    .beat_o     (beat_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef SPLIT_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input cw_t obs, input cw_t exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat b presents elements b, b+STRIDE, b+2*STRIDE, ... on lanes 0, 1, 2, ...
  function automatic cw_t lanes_ref(input vec_t v, input int b);
    cw_t r = '0;
    for (int j = 0; j < int'(LANES); j++) r[j*N +: N] = v[b + j*int'(STRIDE)];
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".valid"}, cw_t'(valid_o), cw_t'(0));
    check({tag, ".lanes"}, cw_t'(lanes_o), cw_t'(0));
    check({tag, ".beat"},  cw_t'(beat_o),  cw_t'(0));
    check({tag, ".last"},  cw_t'(last_o),  cw_t'(0));
    check({tag, ".busy"},  cw_t'(busy_o),  cw_t'(0));
    check({tag, ".done"},  cw_t'(done_o),  cw_t'(0));
  endtask

  // Starts a split of v, then models it beat by beat. Stalls either random or on two chosen beats
  // for stall_len cycles each; poke_beat injects a garbage vector plus start; abort_beat resets.
  task automatic run_split(input string tag, input vec_t v, input int stall_a, input int stall_b,
                           input int stall_len, input bit rand_ready, input int poke_beat,
                           input int abort_beat);
    int   b = 0;
    int   stalls = 0;
    int   stall_here = 0;
    int   cycles = 0;
    bit   r;
    bit   poked = 0;
    vec_t recon = '0;
    start_i  = 1'b1;
    vector_i = v;
    ready_i  = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    for (int k = 0; k < int'(V); k++) vector_i[k] = $urandom;
    while (b < int'(STRIDE)) begin
      cycles++;
      if (cycles > 200) begin
        tests++;
        fails++;
        $error("FAIL %s.bound: observed %0d cycles required at most 200", tag, cycles);
        return;
      end
      if (rand_ready) r = ($urandom_range(0, 3) != 0);
      else r = !(((b == stall_a) || (b == stall_b)) && (stall_here < stall_len));
      ready_i = r;
      if ((b == poke_beat) && !poked) begin
        start_i  = 1'b1;
        vector_i = {V{32'hDEAD}};
        poked    = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge CLK);
      check({tag, ".valid"}, cw_t'(valid_o), cw_t'(1));
      check({tag, ".beat"},  cw_t'(beat_o),  cw_t'(b));
      check({tag, ".lanes"}, cw_t'(lanes_o), lanes_ref(v, b));
      check({tag, ".last"},  cw_t'(last_o),  cw_t'(b == int'(STRIDE) - 1));
      check({tag, ".done"},  cw_t'(done_o),  cw_t'(0));
      if (b == abort_beat) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST     = 1'b0;
        start_i = 1'b0;
        @(negedge CLK);
        check_idle_outputs({tag, ".abort"});
`ifdef SPLIT_STALL_CNT_EN
        check({tag, ".abort.stall_cnt"}, cw_t'(stall_cnt_o), cw_t'(0));
`endif
        @(posedge CLK); #1;
        @(negedge CLK);
        check({tag, ".abort.nodone"}, cw_t'(done_o), cw_t'(0));
        @(posedge CLK); #1;
        return;
      end
      if (r) begin
        for (int j = 0; j < int'(LANES); j++) recon[b + j*int'(STRIDE)] = lanes_o[j];
        b++;
        stall_here = 0;
      end else begin
        stalls++;
        stall_here++;
      end
      @(posedge CLK); #1;
    end
    start_i = 1'b0;
    ready_i = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check({tag, ".done_pulse"}, cw_t'(done_o),  cw_t'(1));
    check({tag, ".done_valid"}, cw_t'(valid_o), cw_t'(0));
    check({tag, ".done_busy"},  cw_t'(busy_o),  cw_t'(1));
`ifdef SPLIT_STALL_CNT_EN
    check({tag, ".stall_cnt"}, cw_t'(stall_cnt_o), cw_t'(stalls));
`endif
    @(posedge CLK); #1;
    @(negedge CLK);
    check_idle_outputs({tag, ".after"});
`ifdef SPLIT_STALL_CNT_EN
    check({tag, ".stall_hold"}, cw_t'(stall_cnt_o), cw_t'(stalls));
`endif
    check({tag, ".roundtrip"}, cw_t'(recon), cw_t'(v));
    @(posedge CLK); #1;
  endtask

  initial begin
    vec_t base;
    vec_t rv;
    for (int k = 0; k < int'(V); k++) base[k] = 32'h100 + k;

    RST      = 1'b1;
    start_i  = 1'b1;
    ready_i  = 1'b1;
    vector_i = base;
    @(posedge CLK); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check_idle_outputs("reset");
`ifdef SPLIT_STALL_CNT_EN
      check("reset.stall_cnt", cw_t'(stall_cnt_o), cw_t'(0));
`endif
      @(posedge CLK); #1;
    end
    RST = 1'b0;

    // start still high: the first edge with RST low accepts it
    run_split("basic", base, -1, -1, 0, 1'b0, -1, -1);
    run_split("backpressure", base, 1, 3, 3, 1'b0, -1, -1);
    run_split("snapshot", base, -1, -1, 0, 1'b0, 2, -1);
    run_split("abort", base, -1, -1, 0, 1'b0, -1, 3);
    run_split("post_abort", base, -1, -1, 0, 1'b0, -1, -1);

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < int'(V); k++) rv[k] = $urandom;
      run_split("random", rv, -1, -1, 0, 1'b1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
